// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline sequencing controller
package pipe_ctrl_pkg;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_MD  = 1'b1
  } md_state_e;

  localparam logic MD_OP_MUL = 1'b0;
  localparam logic MD_OP_DIV = 1'b1;

endpackage

// File: rtl/md_timer.sv
// rtl/md_timer.sv - mult/div occupancy down-counter with zero flag
module md_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Counts down freely, even while the pipeline is frozen, and parks at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencing for load-use, branches, mult/div and memory waits
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_wnum,
  input  logic       id_md_start,
  input  logic       id_md_op,
  input  logic       id_reads_hilo,
  input  logic       ex_branch_taken,
  input  logic       ext_stall,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       id_ex_en,
  output logic       back_en,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       md_start,
  output logic       md_busy
);

  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  md_state_e   r_state;
  md_state_e   w_state_nxt;
  logic        r_md_start;
  logic        w_luse;
  logic        w_mdhaz;
  logic        w_hold;
  logic        w_issue;
  logic        w_cnt_zero;
  logic [CW-1:0] w_load_val;

  assign w_luse = ex_mem_read && (ex_wnum != 5'd0) &&
                  ((id_use_rs && (id_rs == ex_wnum)) || (id_use_rt && (id_rt == ex_wnum)));
  assign w_mdhaz = (r_state == ST_MD) && (id_reads_hilo || id_md_start);
  assign w_hold  = w_luse || w_mdhaz;
  assign w_issue = id_md_start && !ext_stall && !ex_branch_taken && !w_hold;
  assign w_load_val = (id_md_op == MD_OP_DIV) ? DIV_LOAD : MUL_LOAD;

  md_timer #(.W(CW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_issue),
    .i_load_val (w_load_val),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_md_start <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_md_start <= w_issue;
    end
  end

  // Expiry is honoured even under ext_stall so the busy window never stretches.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (w_issue) w_state_nxt = ST_MD;
      ST_MD:   if (w_cnt_zero) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    back_en     = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (ext_stall) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      id_ex_en = 1'b0;
      back_en  = 1'b0;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (w_hold) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
    md_start = r_md_start;
    md_busy  = (r_state == ST_MD);
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl against a cycle-window model
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, ex_wnum;
  logic id_use_rs, id_use_rt, ex_mem_read, id_md_start, id_md_op;
  logic id_reads_hilo, ex_branch_taken, ext_stall;
  logic pc_en, if_id_en, id_ex_en, back_en, if_id_flush, id_ex_flush, md_start, md_busy;

  pipe_hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_mem_read(ex_mem_read), .ex_wnum(ex_wnum),
    .id_md_start(id_md_start), .id_md_op(id_md_op), .id_reads_hilo(id_reads_hilo),
    .ex_branch_taken(ex_branch_taken), .ext_stall(ext_stall),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .back_en(back_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .md_start(md_start), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  wire [7:0] obs = {pc_en, if_id_en, id_ex_en, back_en, if_id_flush, id_ex_flush, md_start, md_busy};

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int md_issue_cyc = -1;
  int md_len = 0;
  logic [7:0] exp_v;

  // Reference: the mult/div unit is busy for the md_len cycles following the issue cycle.
  function automatic bit m_busy();
    return (md_issue_cyc >= 0) && (cyc > md_issue_cyc) && (cyc <= md_issue_cyc + md_len);
  endfunction

  function automatic bit m_luse();
    return ex_mem_read && (ex_wnum != 0) &&
           ((id_use_rs && id_rs == ex_wnum) || (id_use_rt && id_rt == ex_wnum));
  endfunction

  function automatic bit m_hold();
    return m_luse() || (m_busy() && (id_reads_hilo || id_md_start));
  endfunction

  function automatic logic [7:0] model_exp();
    logic [7:0] e;
    if (ext_stall)            e = 8'b0000_0000;
    else if (ex_branch_taken) e = 8'b1111_1100;
    else if (m_hold())        e = 8'b0011_0100;
    else                      e = 8'b1111_0000;
    e[1] = (md_issue_cyc >= 0) && (cyc == md_issue_cyc + 1);
    e[0] = m_busy();
    return e;
  endfunction

  task automatic clear_in();
    id_rs = 0; id_rt = 0; ex_wnum = 0;
    id_use_rs = 0; id_use_rt = 0; ex_mem_read = 0;
    id_md_start = 0; id_md_op = 0; id_reads_hilo = 0;
    ex_branch_taken = 0; ext_stall = 0;
  endtask

  task automatic tick();
    if (id_md_start && !ext_stall && !ex_branch_taken && !m_hold()) begin
      md_issue_cyc = cyc;
      md_len = id_md_op ? 32 : 4;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    clear_in();
    rst = 1'b1;
    #1;
    exp_v = model_exp();
    n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL reset_model: got %b want %b", obs, exp_v); end
    n_cmp++; if (obs !== 8'b1111_0000) begin n_fail++; $display("FAIL reset_const: got %b want 11110000", obs); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    int stalls = 0;
    for (int k = 0; k < 4; k++) begin
      clear_in();
      case (k)
        0: begin ex_mem_read = 1; ex_wnum = 3; id_rs = 3; id_use_rs = 1; end
        1: begin id_rs = 3; id_use_rs = 1; end
        2: begin ex_mem_read = 1; ex_wnum = 0; id_rs = 0; id_use_rs = 1; id_rt = 0; id_use_rt = 1; end
        default: begin ex_mem_read = 1; ex_wnum = 7; id_rt = 7; id_use_rt = 1; id_rs = 7; end
      endcase
      #1; exp_v = model_exp();
      if (k < 3 && obs[7] === 1'b0) stalls++;
      n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL load_use k%0d: got %b want %b", k, obs, exp_v); end
      tick();
    end
    n_cmp++; if (stalls !== 1) begin n_fail++; $display("FAIL load_use_bubbles: got %0d want 1", stalls); end
  endtask

  task automatic test_branch_over_luse();
    clear_in();
    ex_mem_read = 1; ex_wnum = 5; id_rs = 5; id_use_rs = 1; ex_branch_taken = 1;
    #1; exp_v = model_exp();
    n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL branch_luse: got %b want %b", obs, exp_v); end
    n_cmp++; if (obs !== 8'b1111_1100) begin n_fail++; $display("FAIL branch_luse_const: got %b want 11111100", obs); end
    tick();
    clear_in(); id_md_start = 1; id_md_op = 1; ex_branch_taken = 1;
    #1; exp_v = model_exp();
    n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL branch_md: got %b want %b", obs, exp_v); end
    tick();
    clear_in();
    #1;
    n_cmp++; if (md_start !== 1'b0 || md_busy !== 1'b0) begin n_fail++; $display("FAIL branch_md_noissue: got start=%b busy=%b want 0 0", md_start, md_busy); end
    tick();
  endtask

  task automatic test_div_mfhi();
    int busy_n = 0, start_n = 0, stall_n = 0;
    clear_in(); id_md_start = 1; id_md_op = 1;
    #1; exp_v = model_exp();
    n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL div_issue: got %b want %b", obs, exp_v); end
    tick();
    for (int k = 0; k < 40; k++) begin
      clear_in(); id_reads_hilo = 1;
      #1; exp_v = model_exp();
      busy_n += md_busy; start_n += md_start; stall_n += id_ex_flush;
      n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL div_mfhi c%0d: got %b want %b", k, obs, exp_v); end
      tick();
    end
    n_cmp++; if (busy_n !== 32) begin n_fail++; $display("FAIL div_busy_len: got %0d want 32", busy_n); end
    n_cmp++; if (start_n !== 1) begin n_fail++; $display("FAIL div_start_pulses: got %0d want 1", start_n); end
    n_cmp++; if (stall_n !== 32) begin n_fail++; $display("FAIL div_mfhi_held: got %0d want 32", stall_n); end
  endtask

  task automatic test_mult_add();
    int busy_n = 0, stall_n = 0;
    clear_in(); id_md_start = 1; id_md_op = 0;
    #1; exp_v = model_exp();
    n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL mult_issue: got %b want %b", obs, exp_v); end
    tick();
    for (int k = 0; k < 7; k++) begin
      clear_in(); id_rs = 5; id_use_rs = 1; id_rt = 6; id_use_rt = 1;
      #1; exp_v = model_exp();
      busy_n += md_busy; stall_n += !pc_en;
      n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL mult_add c%0d: got %b want %b", k, obs, exp_v); end
      tick();
    end
    n_cmp++; if (busy_n !== 4 || stall_n !== 0) begin n_fail++; $display("FAIL mult_busy: got busy=%0d stalls=%0d want 4 0", busy_n, stall_n); end
  endtask

  task automatic test_ext_stall_mid_div();
    int busy_n = 0;
    clear_in(); id_md_start = 1; id_md_op = 1;
    #1; tick();
    for (int k = 0; k < 36; k++) begin
      clear_in(); ext_stall = (k >= 3 && k < 8);
      #1; exp_v = model_exp();
      busy_n += md_busy;
      n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL ext_stall c%0d: got %b want %b", k, obs, exp_v); end
      tick();
    end
    n_cmp++; if (busy_n !== 32) begin n_fail++; $display("FAIL ext_stall_busy_len: got %0d want 32", busy_n); end
  endtask

  task automatic test_async_reset_mid_md();
    clear_in(); id_md_start = 1; id_md_op = 1;
    #1; tick();
    for (int k = 0; k < 21; k++) begin
      clear_in(); #1; tick();
    end
    clear_in();
    #1;
    n_cmp++; if (md_busy !== 1'b1) begin n_fail++; $display("FAIL pre_reset_busy: got %b want 1", md_busy); end
    rst = 1'b1;
    md_issue_cyc = -1;
    #1; exp_v = model_exp();
    n_cmp++; if (obs !== exp_v || md_busy !== 1'b0 || md_start !== 1'b0) begin n_fail++; $display("FAIL async_reset: got %b want %b", obs, exp_v); end
    #1; rst = 1'b0;
    tick();
    clear_in(); id_reads_hilo = 1;
    #1; exp_v = model_exp();
    n_cmp++; if (obs !== 8'b1111_0000 || obs !== exp_v) begin n_fail++; $display("FAIL post_reset_mfhi: got %b want 11110000", obs); end
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      clear_in();
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      ex_wnum = 5'($urandom_range(0, 3));
      id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
      ex_mem_read = ($urandom_range(0, 2) == 0);
      id_md_start = ($urandom_range(0, 5) == 0); id_md_op = ($urandom_range(0, 3) == 0);
      id_reads_hilo = ($urandom_range(0, 4) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      ext_stall = ($urandom_range(0, 7) == 0);
      #1; exp_v = model_exp();
      n_cmp++; if (obs !== exp_v) begin n_fail++; $display("FAIL random c%0d: got %b want %b", k, obs, exp_v); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_over_luse();
    test_div_mfhi();
    test_mult_add();
    test_ext_stall_mid_div();
    test_async_reset_mid_md();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
